// File: rtl/get_data_pipe.sv
// Fetch stage that pulls C/D/read ROM data for one search tuple at a time.
// Define GET_DATA_C_CACHE_EN to add a 4-entry per-base C cache.
module get_data_pipe #(
    parameter int IDX_W   = 8,
    parameter int ADDR_W  = 12,
    parameter int POS_W   = 5,
    parameter int DAT_W   = 8,
    parameter int RD_W    = 2,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  i_in,
    input  logic [IDX_W-1:0]  z_in,
    input  logic [IDX_W-1:0]  k_in,
    input  logic [IDX_W-1:0]  l_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [POS_W-1:0]  pos_in,
    output logic              ce_rom_C,
    output logic [1:0]        addr_rom_C,
    output logic              ce_rom_RD,
    output logic [IDX_W-1:0]  addr_rom_RD,
    input  logic [DAT_W-1:0]  data_C,
    input  logic [DAT_W-1:0]  d_i,
    input  logic [RD_W-1:0]   read_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  i_out,
    output logic [IDX_W-1:0]  z_out,
    output logic [IDX_W-1:0]  k_out,
    output logic [IDX_W-1:0]  l_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [POS_W-1:0]  pos_out,
    output logic [DAT_W-1:0]  d_i_out,
    output logic [RD_W-1:0]   read_i_out,
    output logic [DAT_W-1:0]  C_out,
    output logic              need_occ,
    output logic              pos_err
);

    localparam logic [POS_W-1:0] P_NONE  = POS_W'(0);
    localparam logic [POS_W-1:0] P_A_INS = POS_W'(1);
    localparam logic [POS_W-1:0] P_T_INS = POS_W'(4);
    localparam logic [POS_W-1:0] P_A_DEL = POS_W'(5);
    localparam logic [POS_W-1:0] P_T_DEL = POS_W'(8);
    localparam logic [POS_W-1:0] P_STOP1 = POS_W'(9);
    localparam logic [POS_W-1:0] P_T_SNP = POS_W'(18);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    typedef enum logic [1:0] {CL_NONE, CL_INS, CL_DEL, CL_NOROM} cls_t;

    state_t state, state_nxt;
    cls_t   in_cls, cls_q;
    logic   in_undef;
    logic [POS_W-1:0] pos_m1;
    logic [1:0] in_base, base_q;
    logic   accept, skip, done;
    logic   in_hit, hit_q;
    logic [DAT_W-1:0] hit_c_in, hit_c_q;
    logic [2:0] cnt;

    logic [IDX_W-1:0]  i_q, z_q, k_q, l_q;
    logic [ADDR_W-1:0] addr_q;
    logic [POS_W-1:0]  pos_q;

    // INS and DEL codes both map their base onto (pos-1) mod 4
    assign pos_m1  = pos_in - POS_W'(1);
    assign in_base = pos_m1[1:0];

    always_comb begin
        in_cls   = CL_NOROM;
        in_undef = 1'b0;
        unique case (1'b1)
            (pos_in == P_NONE):
                in_cls = CL_NONE;
            (pos_in >= P_A_INS && pos_in <= P_T_INS):
                in_cls = CL_INS;
            (pos_in >= P_A_DEL && pos_in <= P_T_DEL):
                in_cls = CL_DEL;
            (pos_in >= P_STOP1 && pos_in <= P_T_SNP):
                in_cls = CL_NOROM;
            default:
                in_undef = 1'b1;
        endcase
    end

`ifdef GET_DATA_C_CACHE_EN
    logic [3:0]       cache_v;
    logic [DAT_W-1:0] cache_d [4];

    assign in_hit   = (in_cls == CL_INS || in_cls == CL_DEL)
                      && cache_v[in_base];
    assign hit_c_in = cache_d[in_base];
    assign hit_c_q  = cache_d[base_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_v <= '0;
            cache_d <= '{default: '0};
        end else if (done && !hit_q
                     && (cls_q == CL_INS || cls_q == CL_DEL)) begin
            cache_v[base_q] <= 1'b1;
            cache_d[base_q] <= data_C;
        end
    end
`else
    assign in_hit   = 1'b0;
    assign hit_c_in = '0;
    assign hit_c_q  = '0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign skip      = (in_cls == CL_NOROM)
                       || (in_cls == CL_INS && in_hit);
    assign done      = (state == FETCH) && (cnt == 3'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = skip ? HOLD : FETCH;
            FETCH: if (done) state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ce_rom_C    = 1'b0;
        addr_rom_C  = '0;
        ce_rom_RD   = 1'b0;
        addr_rom_RD = '0;
        if (state == FETCH) begin
            if ((cls_q == CL_INS || cls_q == CL_DEL) && !hit_q) begin
                ce_rom_C   = 1'b1;
                addr_rom_C = base_q;
            end
            if (cls_q == CL_NONE || cls_q == CL_DEL) begin
                ce_rom_RD   = 1'b1;
                addr_rom_RD = i_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q <= '0; z_q <= '0; k_q <= '0; l_q <= '0;
            addr_q <= '0; pos_q <= '0;
            cls_q <= CL_NONE; base_q <= '0; hit_q <= 1'b0;
            cnt <= '0;
            i_out <= '0; z_out <= '0; k_out <= '0; l_out <= '0;
            addr_out <= '0; pos_out <= '0;
            d_i_out <= '0; read_i_out <= '0; C_out <= '0;
            need_occ <= 1'b0; pos_err <= 1'b0;
        end else begin
            pos_err <= 1'b0;
            if (accept) begin
                i_q <= i_in; z_q <= z_in; k_q <= k_in; l_q <= l_in;
                addr_q <= addr_in; pos_q <= pos_in;
                cls_q  <= in_cls;
                base_q <= in_base;
                hit_q  <= in_hit;
                cnt    <= 3'(ROM_LAT);
                pos_err <= in_undef;
                if (skip) begin
                    i_out <= i_in; z_out <= z_in;
                    k_out <= k_in; l_out <= l_in;
                    addr_out <= addr_in; pos_out <= pos_in;
                    d_i_out    <= '0;
                    read_i_out <= '0;
                    C_out      <= in_hit ? hit_c_in : '0;
                    need_occ   <= in_hit;
                end
            end else if (state == FETCH) begin
                cnt <= cnt - 3'd1;
                if (done) begin
                    i_out <= i_q; z_out <= z_q;
                    k_out <= k_q; l_out <= l_q;
                    addr_out <= addr_q; pos_out <= pos_q;
                    d_i_out    <= (cls_q == CL_NONE) ? d_i : '0;
                    read_i_out <= (cls_q == CL_DEL) ? read_i : '0;
                    if (cls_q == CL_INS || cls_q == CL_DEL) begin
                        C_out    <= hit_q ? hit_c_q : data_C;
                        need_occ <= 1'b1;
                    end else begin
                        C_out    <= '0;
                        need_occ <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/get_data_pipe.md
GET_DATA_PIPE -- requirements
Module: get_data_pipe

Interface
REQ-001 Parameters SHALL be as follows:
  - IDX_W, 8, width of i/z/k/l.
  - ADDR_W, 12, width of the parameter address.
  - POS_W, 5, width of the position code.
  - DAT_W, 8, width of C and D data.
  - RD_W, 2, width of the read symbol.
  - ROM_LAT, 1, ROM read latency in cycles; legal range 1..4.
REQ-002 Ports SHALL be as follows:
  - clk  in  1  single clock; all logic on the rising edge.
  - rst  in  1  synchronous, active-high reset.
  - in_valid  in  1  input tuple valid.
  - in_ready  out  1  block can accept a tuple.
  - i_in, z_in, k_in, l_in  in  IDX_W each  search parameters.
  - addr_in  in  ADDR_W  parameter address.
  - pos_in  in  POS_W  position code (shared config header encodings).
  - ce_rom_C  out  1  C ROM enable.
  - addr_rom_C  out  2  C ROM address (base index).
  - ce_rom_RD  out  1  read/D ROM enable.
  - addr_rom_RD  out  IDX_W  read/D ROM address.
  - data_C  in  DAT_W  C ROM data.
  - d_i  in  DAT_W  D ROM data.
  - read_i  in  RD_W  read ROM data.
  - out_valid  out  1  output tuple valid.
  - out_ready  in  1  downstream accepts the tuple.
  - i_out, z_out, k_out, l_out, addr_out, pos_out  out  per the matching input  registered copies.
  - d_i_out  out  DAT_W  registered D data.
  - read_i_out  out  RD_W  registered read data.
  - C_out  out  DAT_W  registered C data.
  - need_occ  out  1  tuple requires the Occ lookup.
  - pos_err  out  1  one-cycle pulse for an undefined position code.

Function
REQ-003 FSM SHALL have the states IDLE, FETCH and HOLD.
  - in_ready=1 only in IDLE.
REQ-004 Accept SHALL occur when in_valid&in_ready at edge t.
  - The tuple is latched into an internal register.
  - State goes to FETCH.
  - A latency counter loads ROM_LAT.
REQ-005 In FETCH, ce/addr SHALL be driven from the latched tuple every cycle.
  - NONE: ce_rom_RD=1, addr_rom_RD=i.
  - x_INSERTION: ce_rom_C=1, addr_rom_C=x (A=0, C=1, G=2, T=3).
  - x_DELETION: both enables=1, addr_rom_C=x, addr_rom_RD=i.
  - STOP_1/2, MATCH, SNP, undefined: no enables.
REQ-006 The counter SHALL decrement each FETCH cycle; at 0 the ROM data is captured and state goes to HOLD.
  - out_valid rises at t+1+ROM_LAT.
REQ-007 No-ROM positions SHALL skip FETCH.
  - State goes directly to HOLD.
  - out_valid at t+1.
  - d_i_out, read_i_out and C_out=0.
REQ-008 Captured fields SHALL be set by position class; all other data fields are 0.
  - NONE: d_i_out.
  - INSERTION: C_out.
  - DELETION: C_out and read_i_out.
REQ-009 need_occ SHALL be 1 for the INSERTION and DELETION classes and 0 otherwise.
REQ-010 In HOLD, all outputs SHALL remain stable while out_ready=0.
  - out_valid&out_ready returns the FSM to IDLE.
  - out_valid falls on the next cycle.
REQ-011 Throughput SHALL be one tuple per transaction, with no overlap.
  - in_ready rises the cycle after the HOLD handshake.
REQ-012 An undefined position SHALL be handled as no-ROM.
  - pos_err pulses for exactly one cycle, in the cycle after accept.
REQ-013 Enables SHALL be 0 in IDLE and HOLD.
  - ROM addresses are 0 whenever their enable is 0.

Reset
REQ-014 rst=1 SHALL take effect at the next edge.
  - State goes to IDLE.
  - All outputs, including data and enables, go to 0.
  - in_ready=1 on the first cycle after rst falls.
REQ-015 Reset during FETCH or HOLD SHALL abandon the tuple with no output handshake.
  - in_valid is ignored while rst=1.

Configuration
REQ-016 Macro GET_DATA_C_CACHE_EN SHALL control a 4-entry C cache.
  - Defined: the cache holds a valid bit and value per base.
  - An INSERTION hit skips FETCH, gives out_valid at t+1, and keeps ce_rom_C=0.
  - A DELETION hit still fetches read_i, with no C enable.
  - A miss fills the entry on capture.
  - Reset clears all valid bits.
  - Undefined: there is no cache, and behaviour is exactly REQ-005..REQ-008.

Verification
REQ-017 The bench SHALL cover the following scenarios:
  - ROM_LAT=2, NONE, i=5, D[5]=0x21 -> ce_rom_RD=1/addr=5 for 2 cycles; out_valid at t+3; d_i_out=0x21, need_occ=0, C_out=0.
  - ROM_LAT=1, G_DELETION, i=7, C[2]=0x40, read[7]=3 -> addr_rom_C=2; C_out=0x40, read_i_out=3, need_occ=1, out_valid at t+2.
  - A_MATCH -> no enables; out_valid at t+1; all data fields 0.
  - HOLD with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; release -> in_ready=1 the next cycle.
  - rst asserted in FETCH -> next cycle all outputs 0, state IDLE, no out_valid.
  - Cache enabled: two T_INSERTIONs, C[3]=0x90 -> the first takes t+1+ROM_LAT; the second gives out_valid at t+1, ce_rom_C=0, C_out=0x90.
